// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one unified memory port with registered requests.
// Define ARB_FAIR_EN to alternate fetch and data grants under contention.
module mem_arbiter #(
    parameter int N  = 64,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [N-1:0]  if_addr,
    output logic [IW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [N-1:0]  dm_addr,
    input  logic [N-1:0]  dm_wdata,
    output logic [N-1:0]  dm_rdata,
    output logic          dm_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [N-1:0]  mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata,
    input  logic          mem_ack,
    output logic          stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_e;

    state_e         state_q;
    state_e         state_d;
    logic           mem_req_q;
    logic           mem_we_q;
    logic           we_q;
    logic [N-1:0]   mem_addr_q;
    logic [N-1:0]   mem_wdata_q;
    logic [IW-1:0]  if_rdata_q;
    logic           if_valid_q;
    logic [N-1:0]   dm_rdata_q;
    logic           dm_valid_q;
    logic           fair_q;

    logic           ack;
    logic           issue;
    logic           pick_i;
    logic           pick_d;
    logic           start_d;
    logic           start_i;

    // An ack only counts once the request is actually on the bus.
    assign ack    = mem_req_q & mem_ack;
    assign issue  = (state_q != IDLE) & ~mem_req_q;
    assign pick_i = if_req & (~dm_req | fair_q);
    assign pick_d = dm_req & ~pick_i;

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        start_i = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!if_valid_q && !dm_valid_q) begin
                    if (pick_d) begin
                        state_d = GNT_D;
                        start_d = 1'b1;
                    end else if (pick_i) begin
                        state_d = GNT_I;
                        start_i = 1'b1;
                    end
                end
            end
            GNT_D, GNT_I: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if (start_d) begin
                mem_addr_q  <= dm_addr;
                mem_wdata_q <= dm_wdata;
                we_q        <= dm_we;
            end
            if (start_i) begin
                mem_addr_q  <= if_addr;
                mem_wdata_q <= '0;
                we_q        <= 1'b0;
            end
            if (issue) begin
                mem_req_q <= 1'b1;
                mem_we_q  <= we_q;
            end
            if (ack) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
                if (state_q == GNT_I) begin
                    if_rdata_q <= mem_rdata[IW-1:0];
                    if_valid_q <= 1'b1;
                end else begin
                    if (!mem_we_q) begin
                        dm_rdata_q <= mem_rdata;
                    end
                    dm_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef ARB_FAIR_EN
    // Set after a data completion so the next contended grant goes to fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fair_q <= 1'b0;
        end else if (ack) begin
            fair_q <= (state_q == GNT_D);
        end
    end
`else
    assign fair_q = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign stall     = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: N, 64, address/data width of the data port and memory bus.
REQ-002 Parameter: IW, 32, instruction width returned on the fetch port (IW <= N).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: if_req  input  1  fetch request; held high by requester until if_valid.
REQ-006 Port: if_addr  input  N  fetch address; stable while if_req high.
REQ-007 Port: if_rdata  output  IW  fetched instruction (mem_rdata[IW-1:0]); valid when if_valid.
REQ-008 Port: if_valid  output  1  one-cycle fetch completion pulse.
REQ-009 Port: dm_req  input  1  data request; held high until dm_valid.
REQ-010 Port: dm_we  input  1  1 = write, 0 = read; stable while dm_req high.
REQ-011 Port: dm_addr, dm_wdata  input  N each  data address / write data.
REQ-012 Port: dm_rdata  output  N  read data; valid when dm_valid and the op was a read.
REQ-013 Port: dm_valid  output  1  one-cycle data completion pulse (reads and writes).
REQ-014 Port: mem_req, mem_we  output  1 each  unified-memory request / write strobe.
REQ-015 Port: mem_addr, mem_wdata  output  N each  memory address / write data.
REQ-016 Port: mem_rdata  input  N  memory read data, sampled in the mem_ack cycle.
REQ-017 Port: mem_ack  input  1  memory completion; may assert in the first mem_req cycle.
REQ-018 Port: stall  output  1  pipeline freeze request to the datapath.

Function
REQ-019 FSM states IDLE, GNT_D, GNT_I; IDLE -> GNT_D or GNT_I on sampled request; GNT_x -> IDLE on the mem_ack cycle.
REQ-020 In IDLE with both requests high, GNT_D is selected (data is the older instruction) unless REQ-034 applies.
REQ-021 mem_req, mem_we, mem_addr, mem_wdata registered: driven from the cycle after the grant decision, held constant until mem_ack.
REQ-022 mem_we = 0 in GNT_I; mem_we = registered dm_we in GNT_D; mem_wdata = 0 in GNT_I.
REQ-023 On mem_ack, read data captured into if_rdata or dm_rdata; matching valid pulses exactly one cycle later, concurrent with return to IDLE.
REQ-024 Minimum latency request-high to valid: 3 cycles (ack in first mem_req cycle); each extra wait cycle adds one.
REQ-025 No new grant decided in the cycle a valid pulses; the requester's still-high req in that cycle is ignored (requester drops req after valid).
REQ-026 if_rdata/dm_rdata hold last captured value until the next capture of the same port.
REQ-027 mem_ack while in IDLE is ignored; no valid, no state change.
REQ-028 stall = (if_req & ~if_valid) | (dm_req & ~dm_valid), combinational.
REQ-029 At most one memory transaction outstanding; requester dropping req mid-transaction does not abort it; its valid still pulses.

Reset
REQ-030 reset asserted: state -> IDLE immediately, regardless of clock.
REQ-031 Reset values: mem_req, mem_we, if_valid, dm_valid = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; fairness flag = 0.
REQ-032 Reset mid-transaction abandons it; no valid pulse follows; a late mem_ack after release is ignored per REQ-027.
REQ-033 First grant decision no earlier than the first rising edge after reset deasserts.

Configuration
REQ-034 Macro ARB_FAIR_EN defined: a one-bit flag set on each GNT_D completion, cleared on each GNT_I completion; with flag set and both requests high, GNT_I wins.
REQ-035 Macro ARB_FAIR_EN undefined: strict data priority per REQ-020; flag logic absent; fetch may starve while dm_req stays asserted.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x40, mem_ack in first mem_req cycle, mem_rdata=0x8B020020 -> mem_addr=0x40, if_valid 3 cycles after if_req, if_rdata=0x8B020020.
REQ-037 Data write with 2 wait states: dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xA5 -> mem_req held 3 cycles with mem_we=1, mem_wdata=0xA5, dm_valid 5 cycles after dm_req, stall high through the cycle before dm_valid.
REQ-038 Simultaneous if_req and dm_req read (addr 0x08, mem_rdata=0x1234) -> data served first, dm_rdata=0x1234, then fetch issued; if_valid after dm_valid.
REQ-039 Continuous dm_req, if_req held: without ARB_FAIR_EN no fetch grant in 20 cycles; with ARB_FAIR_EN grants alternate D,I,D,I.
REQ-040 Assert reset while GNT_D with mem_ack pending -> mem_req=0 same cycle, no dm_valid, state IDLE; stray mem_ack afterwards produces no valid.
REQ-041 mem_ack pulsed in IDLE with no requests -> all outputs unchanged, stall=0.
